ordering_exchange: RTL and testbench

Per-replica tour store and exchange engine. It sits directly downstream of `replica`. It consumes the registered `exchange_ex` command and, in lockstep with every other replica, streams its stored city ordering out to both neighbours. At the same time it overwrites its own ordering and `total_data_t` with the copy from the selected source (SELF, PREV or FOLW). The updated `self_data` it presents is what the next `replica` test reads.

---
 rtl/ordering_exchange.sv | 184 ++++++++++++++++++
 tb/tb_ordering_exchange.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ordering_exchange.sv
// ordering_exchange: per-replica tour RAM that streams its ordering to both neighbours
// while overwriting itself from SELF/PREV/FOLW. Optional checker macro: ORDERING_CHECK_EN.
package ordering_exchange_pkg;
    typedef enum logic [1:0] {NOP = 2'd0, SELF = 2'd1, PREV = 2'd2, FOLW = 2'd3} exchange_command_t;
    typedef logic [31:0] total_data_t;
endpackage

module ordering_exchange
    import ordering_exchange_pkg::*;
#(
    parameter int city_num = 32,
    parameter int cw       = $clog2(city_num)
) (
    input  logic              clk,
    input  logic              reset,
    input  exchange_command_t exchange_cmd,
    input  logic [cw-1:0]     prev_ordering,
    input  logic [cw-1:0]     folw_ordering,
    output logic [cw-1:0]     out_ordering,
    input  total_data_t       prev_total,
    input  total_data_t       folw_total,
    output total_data_t       self_total,
    input  logic              init_we,
    input  logic [cw-1:0]     init_addr,
    input  logic [cw-1:0]     init_data,
    input  total_data_t       init_total,
    input  logic [cw-1:0]     rd_addr,
    output logic [cw-1:0]     rd_data,
    output logic              busy,
    output logic              done,
`ifdef ORDERING_CHECK_EN
    output logic              perm_err,
`endif
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [cw:0] K_ONE  = (cw+1)'(1);
    localparam logic [cw:0] K_LAST = (cw+1)'(city_num);

    state_t            state_q;
    exchange_command_t src_q;
    logic [cw:0]       k_q;
    logic [cw:0]       k_m1;
    total_data_t       total_q;
    logic [cw-1:0]     rd_q;
    logic              busy_q;
    logic              done_q;
    logic [cw-1:0]     mem [city_num];

    logic [cw-1:0]     ram_ra;
    logic              ram_we;
    logic              ex_wr;
    logic [cw-1:0]     ram_wa;
    logic [cw-1:0]     ram_wd;

    assign k_m1 = k_q - K_ONE;

    // Stream read of entry k lands one cycle later; its write-back from the
    // neighbour lags one more cycle, so neighbours always see pre-exchange data.
    always_comb begin
        ram_ra = rd_addr;
        if (state_q == RUN) ram_ra = k_q[cw-1:0];
        ex_wr  = (state_q == RUN) && (k_q != '0) && ((src_q == PREV) || (src_q == FOLW));
        ram_we = 1'b0;
        ram_wa = init_addr;
        ram_wd = init_data;
        if (state_q == IDLE) begin
            ram_we = init_we;
        end else if (ex_wr) begin
            ram_we = 1'b1;
            ram_wa = k_m1[cw-1:0];
            ram_wd = (src_q == PREV) ? prev_ordering : folw_ordering;
        end
        if (reset) ram_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_wd;
    end

    always_ff @(posedge clk) begin
        if (reset) rd_q <= '0;
        else       rd_q <= mem[ram_ra];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= NOP;
            k_q     <= '0;
            total_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (init_we && (init_addr == '0)) total_q <= init_total;
                    if (exchange_cmd != NOP) begin
                        src_q   <= exchange_cmd;
                        k_q     <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        if (exchange_cmd == PREV)      total_q <= prev_total;
                        else if (exchange_cmd == FOLW) total_q <= folw_total;
                    end
                end
                RUN: begin
                    if (k_q == K_LAST) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        k_q <= k_q + K_ONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ORDERING_CHECK_EN
    localparam int SW = 2*cw + 2;

    function automatic logic [cw-1:0] ref_xor();
        logic [cw-1:0] r;
        r = '0;
        for (int i = 0; i < city_num; i++) r = r ^ cw'(i);
        return r;
    endfunction

    localparam logic [SW-1:0] SUM_REF = SW'(city_num * (city_num - 1) / 2);
    localparam logic [cw-1:0] XOR_REF = ref_xor();

    logic [SW-1:0] sum_q;
    logic [SW-1:0] sum_nx;
    logic [cw-1:0] xor_q;
    logic [cw-1:0] xor_nx;
    logic          perm_err_q;

    always_comb begin
        sum_nx = sum_q;
        xor_nx = xor_q;
        if (ex_wr) begin
            sum_nx = sum_q + SW'(ram_wd);
            xor_nx = xor_q ^ ram_wd;
        end
    end

    // The last write and the verdict share the edge into DONE, so use the next-sums.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q      <= '0;
            xor_q      <= '0;
            perm_err_q <= 1'b0;
        end else if (state_q == IDLE) begin
            sum_q <= '0;
            xor_q <= '0;
        end else if (state_q == RUN) begin
            sum_q <= sum_nx;
            xor_q <= xor_nx;
            if ((k_q == K_LAST) && ((src_q == PREV) || (src_q == FOLW)) &&
                ((sum_nx != SUM_REF) || (xor_nx != XOR_REF)))
                perm_err_q <= 1'b1;
        end
    end

    assign perm_err = perm_err_q;
`endif

    assign out_ordering = rd_q;
    assign rd_data      = rd_q;
    assign self_total   = total_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_ordering_exchange.sv
// Directed bench: three chained replicas (city_num=8) exercising SELF/PREV/FOLW
// exchanges, ignored commands, mid-transfer reset and the optional permutation checker.
module tb_ordering_exchange;
  import ordering_exchange_pkg::*;

  localparam int N  = 8;
  localparam int CW = 3;

  typedef logic [N-1:0][CW-1:0] ord_t;
  typedef struct {
    int             inst;
    logic [CW-1:0]  addr;
    logic [CW-1:0]  exp;
  } rd_vec_t;

  logic              clk = 1'b0;
  logic              rst [3];
  exchange_command_t cmd [3];
  logic [CW-1:0]     out_o [3];
  logic [CW-1:0]     prev_o [3];
  logic [CW-1:0]     folw_o [3];
  total_data_t       tot_o [3];
  total_data_t       prev_t [3];
  total_data_t       folw_t [3];
  logic              init_we [3];
  logic [CW-1:0]     init_addr [3];
  logic [CW-1:0]     init_data [3];
  total_data_t       init_total [3];
  logic [CW-1:0]     rd_addr [3];
  logic [CW-1:0]     rd_data [3];
  logic              busy [3];
  logic              done [3];
  logic [1:0]        dbg_state [3];
`ifdef ORDERING_CHECK_EN
  logic              perm_err [3];
`endif

  int checks = 0;
  int errors = 0;
  rd_vec_t tbl[$];

  always #5 clk = ~clk;

  assign prev_o[0] = '0;
  assign prev_o[1] = out_o[0];
  assign prev_o[2] = out_o[1];
  assign folw_o[0] = out_o[1];
  assign folw_o[1] = out_o[2];
  assign folw_o[2] = '0;
  assign prev_t[0] = '0;
  assign prev_t[1] = tot_o[0];
  assign prev_t[2] = tot_o[1];
  assign folw_t[0] = tot_o[1];
  assign folw_t[1] = tot_o[2];
  assign folw_t[2] = '0;

  for (genvar g = 0; g < 3; g++) begin : g_rep
    ordering_exchange #(.city_num(N), .cw(CW)) dut (
      .clk           (clk),
      .reset         (rst[g]),
      .exchange_cmd  (cmd[g]),
      .prev_ordering (prev_o[g]),
      .folw_ordering (folw_o[g]),
      .out_ordering  (out_o[g]),
      .prev_total    (prev_t[g]),
      .folw_total    (folw_t[g]),
      .self_total    (tot_o[g]),
      .init_we       (init_we[g]),
      .init_addr     (init_addr[g]),
      .init_data     (init_data[g]),
      .init_total    (init_total[g]),
      .rd_addr       (rd_addr[g]),
      .rd_data       (rd_data[g]),
      .busy          (busy[g]),
      .done          (done[g]),
`ifdef ORDERING_CHECK_EN
      .perm_err      (perm_err[g]),
`endif
      .dbg_state     (dbg_state[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load(input int inst, input ord_t o, input total_data_t t);
    for (int i = 0; i < N; i++) begin
      init_we[inst]    = 1'b1;
      init_addr[inst]  = CW'(i);
      init_data[inst]  = o[i];
      init_total[inst] = t;
      tick();
    end
    init_we[inst] = 1'b0;
  endtask

  task automatic add_ord(input int inst, input ord_t o);
    rd_vec_t v;
    for (int i = 0; i < N; i++) begin
      v.inst = inst;
      v.addr = CW'(i);
      v.exp  = o[i];
      tbl.push_back(v);
    end
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      rd_addr[tbl[i].inst] = tbl[i].addr;
      tick();
      check($sformatf("%s_inst%0d_addr%0d", nm, tbl[i].inst, tbl[i].addr),
            32'(rd_data[tbl[i].inst]), 32'(tbl[i].exp));
    end
    tbl.delete();
  endtask

  // Full transfer: command at cycle 0, stream of instance m checked on cycles 2..9.
  task automatic xfer(input exchange_command_t c0, input exchange_command_t c1,
                      input exchange_command_t c2, input int m, input ord_t exp_s,
                      input string nm);
    cmd[0] = c0; cmd[1] = c1; cmd[2] = c2;
    tick();
    for (int i = 0; i < 3; i++) cmd[i] = NOP;
    check({nm, "_busy_c1"}, 32'(busy[m]), 32'd1);
    for (int c = 2; c <= N + 1; c++) begin
      tick();
      check($sformatf("%s_stream_c%0d", nm, c), 32'(out_o[m]), 32'(exp_s[c-2]));
    end
    tick();
    check({nm, "_done_c10"}, 32'(done[m]), 32'd1);
    tick();
    check({nm, "_done_c11"}, 32'(done[m]), 32'd0);
    check({nm, "_busy_c11"}, 32'(busy[m]), 32'd0);
  endtask

  ord_t ident, rev, pat, bad, part;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      ident[i] = CW'(i);
      rev[i]   = CW'(N - 1 - i);
    end
    pat = {3'd6, 3'd7, 3'd2, 3'd5, 3'd0, 3'd4, 3'd1, 3'd3};
    bad = {3'd6, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    part = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd4, 3'd1, 3'd3};

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; cmd[i] = NOP; init_we[i] = 1'b0; init_addr[i] = '0;
      init_data[i] = '0; init_total[i] = '0; rd_addr[i] = '0;
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    #0;
    check("rst_state", 32'(dbg_state[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_done", 32'(done[0]), 32'd0);
    check("rst_out", 32'(out_o[0]), 32'd0);
    check("rst_rd", 32'(rd_data[0]), 32'd0);
    check("rst_total", tot_o[0], 32'd0);

    load(0, ident, 100);
    load(1, rev, 200);
    load(2, pat, 300);
    check("load_total0", tot_o[0], 32'd100);
    check("load_total2", tot_o[2], 32'd300);
    add_ord(0, ident); add_ord(1, rev); add_ord(2, pat);
    run_table("load");

    // SELF alone: streams 0..7, nothing changes
    xfer(SELF, NOP, NOP, 0, ident, "self");
    check("self_total", tot_o[0], 32'd100);
    add_ord(0, ident);
    run_table("self_ram");

    // B PREV from A (SELF): B takes 0..7 / 100, streams its old 7..0
    xfer(SELF, PREV, NOP, 1, rev, "prev");
    check("prev_total_b", tot_o[1], 32'd100);
    check("prev_total_a", tot_o[0], 32'd100);
    add_ord(1, ident); add_ord(0, ident); add_ord(2, pat);
    run_table("prev_ram");

    // Middle FOLW / right PREV swap
    xfer(NOP, FOLW, PREV, 2, pat, "swap");
    check("swap_total1", tot_o[1], 32'd300);
    check("swap_total2", tot_o[2], 32'd100);
    add_ord(1, pat); add_ord(2, ident);
    run_table("swap_ram");

    // Command during a running transfer is dropped
    cmd[0] = SELF;
    tick();
    cmd[0] = NOP;
    repeat (3) tick();
    cmd[0] = PREV;
    tick();
    cmd[0] = NOP;
    repeat (5) tick();
    check("ign_done_c10", 32'(done[0]), 32'd1);
    for (int c = 11; c <= 14; c++) begin
      tick();
      check($sformatf("ign_busy_c%0d", c), 32'(busy[0]), 32'd0);
    end
    check("ign_total", tot_o[0], 32'd100);

    // Reset at cycle 5 of a PREV transfer into instance 2
    cmd[1] = SELF; cmd[2] = PREV;
    tick();
    cmd[1] = NOP; cmd[2] = NOP;
    check("rstx_total_c1", tot_o[2], 32'd300);
    repeat (4) tick();
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    check("rstx_busy", 32'(busy[2]), 32'd0);
    check("rstx_total", tot_o[2], 32'd0);
    repeat (4) tick();
    check("rstx_peer_done", 32'(done[1]), 32'd1);
    tick();
    add_ord(2, part);
    run_table("rstx_ram");
    xfer(NOP, SELF, PREV, 2, part, "rerun");
    check("rerun_total", tot_o[2], 32'd300);
    add_ord(2, pat);
    run_table("rerun_ram");

`ifdef ORDERING_CHECK_EN
    check("perm_clean", 32'(perm_err[2]), 32'd0);
    load(1, bad, 50);
    xfer(NOP, SELF, PREV, 2, pat, "perm");
    check("perm_set", 32'(perm_err[2]), 32'd1);
    check("perm_self", 32'(perm_err[1]), 32'd0);
    repeat (4) tick();
    check("perm_sticky", 32'(perm_err[2]), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
